// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction-fetch stage: PC, imem req/ready handshake, IF/ID outputs
//
// Owns the program counter and fetches 16-bit instructions from a wait-stated
// instruction memory. Delivers registered instruction / PC+2 to IF/ID, honours
// stall and redirect, and stops fetching once a HLT instruction is accepted.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   stall             hold IF/ID outputs and the PC
//   redirect          branch taken in ID: flush and refetch from redirect_pc
//   redirect_pc       redirect target
//   imem_req          memory request (address held stable until imem_ready)
//   imem_addr         request address, always from the address register
//   imem_rdata        instruction word, valid with imem_ready
//   imem_ready        memory response, may coincide with the first req cycle
//   if_instr          instruction to IF/ID (NOP_INSTR on bubbles)
//   if_pc_plus2       fetched address + 2
//   if_valid          if_instr is a real fetched instruction
//   pc                next fetch PC
//   fetch_halted      HLT delivered, no further fetches until redirect

module fetch_stage #(
   parameter logic [15:0] RESET_PC   = 16'h0000,
   parameter logic [3:0]  HLT_OPCODE = 4'hF,
   parameter logic [15:0] NOP_INSTR  = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic [15:0] imem_rdata,
   input  logic        imem_ready,
   output logic [15:0] if_instr,
   output logic [15:0] if_pc_plus2,
   output logic        if_valid,
   output logic [15:0] pc,
   output logic        fetch_halted
);

   typedef enum logic [1:0] {
      S_FETCH   = 2'd0,
      S_HOLD    = 2'd1,
      S_DISCARD = 2'd2,
      S_HALTED  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] skid_q, skid_d;
   logic [15:0] instr_q, instr_d;
   logic [15:0] pc_plus2_q, pc_plus2_d;
   logic        valid_q, valid_d;
   logic        halted_q, halted_d;

   logic        accept;
   logic [15:0] accept_word;
   logic [15:0] addr_plus2;

   // addr_q always names the word being fetched or buffered, so it is the
   // base for PC+2 on accept (it equals pc_q in FETCH and HOLD).
   assign addr_plus2 = addr_q + 16'd2;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      addr_d      = addr_q;
      skid_d      = skid_q;
      halted_d    = halted_q;
      instr_d     = instr_q;
      pc_plus2_d  = pc_plus2_q;
      valid_d     = valid_q;
      accept      = 1'b0;
      accept_word = skid_q;

      case (state_q)
         S_FETCH: begin
            if (redirect) begin
               // Any word returned this cycle belongs to the wrong path.
               pc_d = redirect_pc;
               if (imem_ready) begin
                  addr_d = redirect_pc;
               end else begin
                  // The access in flight must complete before the new one.
                  state_d = S_DISCARD;
               end
            end else if (imem_ready) begin
               if (stall) begin
                  skid_d  = imem_rdata;
                  state_d = S_HOLD;
               end else begin
                  accept      = 1'b1;
                  accept_word = imem_rdata;
               end
            end
         end
         S_HOLD: begin
            if (redirect) begin
               pc_d    = redirect_pc;
               addr_d  = redirect_pc;
               state_d = S_FETCH;
            end else if (!stall) begin
               accept      = 1'b1;
               accept_word = skid_q;
               state_d     = S_FETCH;
            end
         end
         S_DISCARD: begin
            if (redirect) begin
               pc_d = redirect_pc;
            end
            if (imem_ready) begin
               // Restart at the newest target, including one arriving now.
               addr_d  = pc_d;
               state_d = S_FETCH;
            end
         end
         S_HALTED: begin
            if (redirect) begin
               halted_d = 1'b0;
               pc_d     = redirect_pc;
               addr_d   = redirect_pc;
               state_d  = S_FETCH;
            end
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase

      if (accept) begin
         pc_d   = addr_plus2;
         addr_d = addr_plus2;
         if (accept_word[15:12] == HLT_OPCODE) begin
            state_d  = S_HALTED;
            halted_d = 1'b1;
         end else begin
            state_d = S_FETCH;
         end
      end

      // IF/ID register: redirect flushes, stall freezes, otherwise a bubble
      // unless a word was accepted this cycle.
      if (redirect) begin
         valid_d = 1'b0;
         instr_d = NOP_INSTR;
      end else if (!stall) begin
         if (accept) begin
            valid_d    = 1'b1;
            instr_d    = accept_word;
            pc_plus2_d = addr_plus2;
         end else begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_FETCH;
         pc_q       <= RESET_PC;
         addr_q     <= RESET_PC;
         skid_q     <= NOP_INSTR;
         instr_q    <= NOP_INSTR;
         pc_plus2_q <= 16'h0000;
         valid_q    <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         addr_q     <= addr_d;
         skid_q     <= skid_d;
         instr_q    <= instr_d;
         pc_plus2_q <= pc_plus2_d;
         valid_q    <= valid_d;
         halted_q   <= halted_d;
      end
   end

   // Request is a decode of the state flop; gating with rst_n keeps it low
   // for the whole reset and lets the first request start right after release.
   assign imem_req     = rst_n && ((state_q == S_FETCH) || (state_q == S_DISCARD));
   assign imem_addr    = addr_q;
   assign if_instr     = instr_q;
   assign if_pc_plus2  = pc_plus2_q;
   assign if_valid     = valid_q;
   assign pc           = pc_q;
   assign fetch_halted = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage against a transaction-level model

module tb_fetch_stage;

   localparam logic [15:0] NOP = 16'h0000;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic [15:0] imem_rdata;
   logic        imem_ready;
   logic [15:0] if_instr;
   logic [15:0] if_pc_plus2;
   logic        if_valid;
   logic [15:0] pc;
   logic        fetch_halted;

   fetch_stage dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .stall        (stall),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_rdata   (imem_rdata),
      .imem_ready   (imem_ready),
      .if_instr     (if_instr),
      .if_pc_plus2  (if_pc_plus2),
      .if_valid     (if_valid),
      .pc           (pc),
      .fetch_halted (fetch_halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // memory model controls
   int          wait_cfg  = 0;      // <0 : random 0..3 wait states
   int          wait_left = 0;
   logic [15:0] hlt_addr  = 16'hFFFF;
   logic        rand_hlt  = 1'b0;
   logic        fired;

   // reference model: next address to be delivered, plus pending conditions
   logic [15:0] m_pc;
   logic        m_halted, m_buf, m_disc;
   logic        have_pred;
   logic        p_hold, p_cont;
   logic [15:0] p_addr;
   logic        p_valid, e_valid;
   logic [15:0] p_instr, p_pp2, e_instr, e_pp2;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
      n_checks++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp_v, $time);
   endtask

   function automatic logic [15:0] word(input logic [15:0] a);
      logic [15:0] w;
      if (a == hlt_addr || (rand_hlt && a[5:1] == 5'h1F)) w = 16'hF000;
      else w = {1'b0, a[15:1]} ^ 16'h0A5A;
      return w;
   endfunction

   function automatic int new_wait();
      return (wait_cfg < 0) ? int'($urandom_range(0, 3)) : wait_cfg;
   endfunction

   task automatic model_reset();
      m_pc = 16'h0000; m_halted = 1'b0; m_buf = 1'b0; m_disc = 1'b0;
      have_pred = 1'b0; p_cont = 1'b0; p_hold = 1'b0;
      wait_left = new_wait();
   endtask

   // Reset pulse mid-cycle; outputs must return to reset values immediately.
   task automatic do_reset();
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_valid",  16'(if_valid), 16'd0);
      chk("rst_instr",  if_instr, NOP);
      chk("rst_pp2",    if_pc_plus2, 16'h0000);
      chk("rst_pc",     pc, 16'h0000);
      chk("rst_req",    16'(imem_req), 16'd0);
      chk("rst_addr",   imem_addr, 16'h0000);
      chk("rst_halted", 16'(fetch_halted), 16'd0);
      stall = 1'b0; redirect = 1'b0; imem_ready = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b1;
      model_reset();
   endtask

   // rmode: 0 none, 1 always, 2 only while an access waits, 3 only with ready
   task automatic step(input logic s, input int rmode, input logic [15:0] rpc);
      logic r, hs, deliver;
      @(negedge clk);
      chk("req", 16'(imem_req), 16'(!(m_buf || m_halted)));
      if (imem_req) chk("addr", imem_addr, p_cont ? p_addr : m_pc);
      chk("pc", pc, m_pc);
      chk("halted", 16'(fetch_halted), 16'(m_halted));
      if (have_pred) begin
         if (p_hold) begin
            chk("hold_valid", 16'(if_valid), 16'(p_valid));
            chk("hold_instr", if_instr, p_instr);
            chk("hold_pp2", if_pc_plus2, p_pp2);
         end else begin
            chk("valid", 16'(if_valid), 16'(e_valid));
            chk("instr", if_instr, e_instr);
            if (e_valid) chk("pc_plus2", if_pc_plus2, e_pp2);
         end
      end
      if (imem_req && wait_left == 0) begin
         imem_ready = 1'b1; imem_rdata = word(imem_addr); wait_left = new_wait();
      end else begin
         imem_ready = 1'b0; imem_rdata = 16'($urandom);
         if (imem_req) wait_left--;
      end
      r = (rmode == 1) || (rmode == 2 && imem_req && !imem_ready) ||
          (rmode == 3 && imem_req && imem_ready);
      if (r) fired = 1'b1;
      stall = s; redirect = r; redirect_pc = rpc;

      hs = imem_req && imem_ready;
      p_hold = 1'b0;
      if (r) begin
         e_valid = 1'b0; e_instr = NOP;
         m_pc = rpc; m_halted = 1'b0; m_buf = 1'b0;
         if (imem_req && !imem_ready) m_disc = 1'b1;
         else if (hs) m_disc = 1'b0;
      end else if (s) begin
         p_hold = 1'b1; p_valid = if_valid; p_instr = if_instr; p_pp2 = if_pc_plus2;
         if (hs) begin
            if (m_disc) m_disc = 1'b0;
            else m_buf = 1'b1;
         end
      end else begin
         deliver = m_buf || (hs && !m_disc);
         if (hs) m_disc = 1'b0;
         if (deliver) begin
            e_valid = 1'b1; e_instr = word(m_pc); e_pp2 = m_pc + 16'd2;
            if (e_instr[15:12] == 4'hF) m_halted = 1'b1;
            m_pc = m_pc + 16'd2; m_buf = 1'b0;
         end else begin
            e_valid = 1'b0; e_instr = NOP;
         end
      end
      p_cont = imem_req && !imem_ready;
      p_addr = imem_addr;
      have_pred = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
      imem_ready = 1'b0; imem_rdata = 16'h0000; fired = 1'b0;
      model_reset();

      // 0-wait streaming from reset
      wait_cfg = 0;
      do_reset();
      for (int i = 0; i < 6; i++) step(1'b0, 0, 16'h0);

      // 2-wait memory: two bubbles between instructions
      wait_cfg = 2;
      for (int i = 0; i < 10; i++) step(1'b0, 0, 16'h0);

      // stall while ready arrives, then release
      wait_cfg = 0;
      for (int i = 0; i < 3; i++) step(1'b1, 0, 16'h0);
      for (int i = 0; i < 3; i++) step(1'b0, 0, 16'h0);

      // redirect during a 3-wait access in flight
      wait_cfg = 3;
      fired = 1'b0;
      for (int i = 0; i < 12 && !fired; i++) step(1'b0, 2, 16'h0100);
      chk("redir_inflight_fired", 16'(fired), 16'd1);
      for (int i = 0; i < 10; i++) step(1'b0, 0, 16'h0);

      // redirect coincident with ready
      wait_cfg = 1;
      fired = 1'b0;
      for (int i = 0; i < 12 && !fired; i++) step(1'b0, 3, 16'h0100);
      chk("redir_ready_fired", 16'(fired), 16'd1);
      step(1'b0, 0, 16'h0);
      chk("redir_ready_addr", imem_addr, 16'h0100);
      for (int i = 0; i < 4; i++) step(1'b0, 0, 16'h0);

      // HLT stops fetch; redirect resumes
      wait_cfg = 0;
      hlt_addr = m_pc + 16'd4;
      for (int i = 0; i < 8; i++) step(1'b0, 0, 16'h0);
      chk("hlt_halted", 16'(fetch_halted), 16'd1);
      chk("hlt_req", 16'(imem_req), 16'd0);
      step(1'b1, 0, 16'h0);
      step(1'b0, 1, 16'h0040);
      step(1'b0, 0, 16'h0);
      chk("hlt_clear", 16'(fetch_halted), 16'd0);
      chk("hlt_resume_addr", imem_addr, 16'h0040);
      hlt_addr = 16'hFFFF;
      for (int i = 0; i < 3; i++) step(1'b0, 0, 16'h0);

      // PC wrap at 16'hFFFE
      step(1'b0, 1, 16'hFFFC);
      step(1'b0, 0, 16'h0);
      step(1'b0, 0, 16'h0);
      step(1'b0, 0, 16'h0);
      chk("wrap_pc", pc, 16'h0000);
      chk("wrap_pp2", if_pc_plus2, 16'h0000);
      for (int i = 0; i < 2; i++) step(1'b0, 0, 16'h0);

      // reset in the middle of a wait-stated access
      wait_cfg = 3;
      for (int i = 0; i < 2; i++) step(1'b0, 0, 16'h0);
      wait_cfg = 0;
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b0, 0, 16'h0);

      // randomized traffic
      wait_cfg = -1;
      rand_hlt = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         step(($urandom % 4) == 0, (($urandom % 16) == 0) ? 1 : 0,
              (($urandom % 8) == 0) ? 16'hFFFC : (16'($urandom) & 16'hFFFE));
      end
      step(1'b0, 0, 16'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
